// File: rtl/imem_loader.sv
// Programmable instruction memory: registered one-cycle fetch port plus a sequential program loader.
// Build option: define IMEM_BOOT_IMAGE_EN to reset the array to the 12-word boot image instead of zeros.
module imem_loader #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 32
) (
  input  logic              clk_i,
  input  logic              clear_i,
  input  logic              fetch_req_i,
  input  logic [ADDR_W-1:0] address_i,
  output logic [DATA_W-1:0] instruction_o,
  output logic              instr_valid_o,
  output logic              fault_o,
  input  logic              load_start_i,
  input  logic              load_valid_i,
  input  logic [DATA_W-1:0] load_data_i,
  input  logic              load_last_i,
  output logic              load_ready_o,
  output logic              load_done_o,
  output logic              busy_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

`ifdef IMEM_BOOT_IMAGE_EN
  localparam bit BOOT_EN = 1'b1;
`else
  localparam bit BOOT_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e            state_q;
  logic [AW-1:0]     wptr_q;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] instr_q, instr_d;
  logic              instr_valid_q, instr_valid_d;
  logic              fault_q, fault_d;
  logic              load_ready_q, load_done_q, busy_q;

  logic in_range_s, fetch_ok_s, wr_s, wr_final_s;

  function automatic logic [DATA_W-1:0] reset_word(input int unsigned idx);
    if (!BOOT_EN) begin
      reset_word = {DATA_W{1'b0}};
    end else begin
      case (idx)
        32'd0:   reset_word = DATA_W'(8'h45);
        32'd1:   reset_word = DATA_W'(8'h59);
        32'd2:   reset_word = DATA_W'(8'h18);
        32'd3:   reset_word = DATA_W'(8'h5C);
        32'd4:   reset_word = DATA_W'(8'h0D);
        32'd5:   reset_word = DATA_W'(8'hB4);
        32'd6:   reset_word = DATA_W'(8'h60);
        32'd7:   reset_word = DATA_W'(8'h1B);
        32'd8:   reset_word = DATA_W'(8'h8C);
        32'd9:   reset_word = DATA_W'(8'h48);
        32'd10:  reset_word = DATA_W'(8'h2C);
        32'd11:  reset_word = DATA_W'(8'hC3);
        default: reset_word = {DATA_W{1'b0}};
      endcase
    end
  endfunction

  // One extra bit so DEPTH == 2**ADDR_W still compares correctly.
  assign in_range_s = ({1'b0, address_i} < (ADDR_W+1)'(DEPTH));
  assign fetch_ok_s = fetch_req_i && (state_q == S_IDLE);
  assign wr_s       = (state_q == S_LOAD) && load_valid_i && load_ready_q;
  assign wr_final_s = wr_s && ((wptr_q == AW'(DEPTH-1)) || load_last_i);

  // Fetch datapath next-state: out-of-range reads return zero and flag a fault.
  always_comb begin
    instr_d       = instr_q;
    instr_valid_d = 1'b0;
    fault_d       = 1'b0;
    if (fetch_ok_s) begin
      instr_valid_d = 1'b1;
      if (in_range_s) begin
        instr_d = mem_q[address_i[AW-1:0]];
        fault_d = 1'b0;
      end else begin
        instr_d = {DATA_W{1'b0}};
        fault_d = 1'b1;
      end
    end else begin
      instr_valid_d = 1'b0;
    end
  end

  // Fetch output registers.
  always_ff @(posedge clk_i or negedge clear_i) begin
    if (!clear_i) begin
      instr_q       <= {DATA_W{1'b0}};
      instr_valid_q <= 1'b0;
      fault_q       <= 1'b0;
    end else begin
      instr_q       <= instr_d;
      instr_valid_q <= instr_valid_d;
      fault_q       <= fault_d;
    end
  end

  // Storage array; reset restores the defined image and discards any partial load.
  always_ff @(posedge clk_i or negedge clear_i) begin
    if (!clear_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= reset_word(i);
      end
    end else if (wr_s) begin
      mem_q[wptr_q] <= load_data_i;
    end
  end

  // Loader FSM with its handshake outputs registered from the next state.
  always_ff @(posedge clk_i or negedge clear_i) begin
    if (!clear_i) begin
      state_q      <= S_IDLE;
      wptr_q       <= {AW{1'b0}};
      load_ready_q <= 1'b0;
      load_done_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          load_done_q <= 1'b0;
          if (load_start_i) begin
            state_q      <= S_LOAD;
            wptr_q       <= {AW{1'b0}};
            load_ready_q <= 1'b1;
            busy_q       <= 1'b1;
          end else begin
            load_ready_q <= 1'b0;
            busy_q       <= 1'b0;
          end
        end
        S_LOAD: begin
          if (wr_s) begin
            wptr_q <= wptr_q + AW'(1);
          end
          if (wr_final_s) begin
            state_q      <= S_DONE;
            load_ready_q <= 1'b0;
            load_done_q  <= 1'b1;
          end
        end
        S_DONE: begin
          state_q      <= S_IDLE;
          load_ready_q <= 1'b0;
          load_done_q  <= 1'b0;
          busy_q       <= 1'b0;
        end
        default: begin
          state_q      <= S_IDLE;
          load_ready_q <= 1'b0;
          load_done_q  <= 1'b0;
          busy_q       <= 1'b0;
        end
      endcase
    end
  end

  assign instruction_o = instr_q;
  assign instr_valid_o = instr_valid_q;
  assign fault_o       = fault_q;
  assign load_ready_o  = load_ready_q;
  assign load_done_o   = load_done_q;
  assign busy_o        = busy_q;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed steps with randomized data against an array model.
module tb_imem_loader;
  localparam int DATA_W = 8;
  localparam int ADDR_W = 8;
  localparam int DEPTH  = 32;

  logic              clk = 1'b0;
  logic              clear;
  logic              fetch_req;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] instruction;
  logic              instr_valid;
  logic              fault;
  logic              load_start;
  logic              load_valid;
  logic [DATA_W-1:0] load_data;
  logic              load_last;
  logic              load_ready;
  logic              load_done;
  logic              busy;

  int checks = 0;
  int errors = 0;

  logic [DATA_W-1:0] ref_mem [DEPTH];
  logic [DATA_W-1:0] exp_instr;

  localparam logic [7:0] BOOT [12] = '{8'h45, 8'h59, 8'h18, 8'h5C, 8'h0D, 8'hB4,
                                       8'h60, 8'h1B, 8'h8C, 8'h48, 8'h2C, 8'hC3};

  imem_loader #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk_i        (clk),
    .clear_i      (clear),
    .fetch_req_i  (fetch_req),
    .address_i    (address),
    .instruction_o(instruction),
    .instr_valid_o(instr_valid),
    .fault_o      (fault),
    .load_start_i (load_start),
    .load_valid_i (load_valid),
    .load_data_i  (load_data),
    .load_last_i  (load_last),
    .load_ready_o (load_ready),
    .load_done_o  (load_done),
    .busy_o       (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] boot_word(input int i);
`ifdef IMEM_BOOT_IMAGE_EN
    if (i < 12) return BOOT[i];
    else return 8'h00;
`else
    return (i < 0) ? BOOT[0] : 8'h00;
`endif
  endfunction

  task automatic reset_model();
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = boot_word(i);
    exp_instr = '0;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input logic [ADDR_W-1:0] a);
    fetch_req = 1'b1;
    address   = a;
    tick();
    fetch_req = 1'b0;
    exp_instr = (int'(a) < DEPTH) ? ref_mem[int'(a)] : 8'h00;
    check("fetch_valid", 32'(instr_valid), 32'd1);
    check("fetch_fault", 32'(fault), (int'(a) >= DEPTH) ? 32'd1 : 32'd0);
    check("fetch_data", 32'(instruction), 32'(exp_instr));
  endtask

  task automatic idle_cycle();
    tick();
    check("idle_valid", 32'(instr_valid), 32'd0);
    check("idle_fault", 32'(fault), 32'd0);
    check("idle_hold", 32'(instruction), 32'(exp_instr));
  endtask

  task automatic start_load(input bit with_fetch, input logic [ADDR_W-1:0] a);
    load_start = 1'b1;
    if (with_fetch) begin
      fetch_req = 1'b1;
      address   = a;
    end
    tick();
    load_start = 1'b0;
    fetch_req  = 1'b0;
    check("start_busy", 32'(busy), 32'd1);
    check("start_ready", 32'(load_ready), 32'd1);
    if (with_fetch) begin
      exp_instr = ref_mem[int'(a)];
      check("start_fetch_valid", 32'(instr_valid), 32'd1);
      check("start_fetch_old", 32'(instruction), 32'(exp_instr));
    end else begin
      check("start_no_valid", 32'(instr_valid), 32'd0);
    end
  endtask

  // mode 0: random data, 1: 0xA0+i, 2: 0x11*(i+1)
  task automatic load_words(input int n, input bit use_last, input bit fetch_during,
                            input int mode, input bit gaps);
    int written = 0;
    logic [DATA_W-1:0] d;
    bit gap;
    while (written < n) begin
      gap = gaps && ($urandom_range(0, 3) == 0);
      case (mode)
        1:       d = 8'hA0 + 8'(written);
        2:       d = 8'h11 * 8'(written + 1);
        default: d = 8'($urandom);
      endcase
      load_valid = !gap;
      load_data  = d;
      load_last  = use_last && (written == n - 1);
      if (fetch_during) begin
        fetch_req = 1'b1;
        address   = 8'($urandom_range(0, DEPTH - 1));
      end
      tick();
      load_valid = 1'b0;
      load_last  = 1'b0;
      fetch_req  = 1'b0;
      check("load_fetch_refused", 32'(instr_valid), 32'd0);
      if (!gap) begin
        ref_mem[written] = d;
        written++;
      end
      if (written < n) begin
        check("load_ready_high", 32'(load_ready), 32'd1);
        check("load_done_low", 32'(load_done), 32'd0);
      end
    end
    check("done_pulse", 32'(load_done), 32'd1);
    check("done_ready_low", 32'(load_ready), 32'd0);
    check("done_busy", 32'(busy), 32'd1);
    fetch_req = fetch_during;
    address   = 8'd0;
    tick();
    fetch_req = 1'b0;
    check("done_fetch_refused", 32'(instr_valid), 32'd0);
    check("after_done_low", 32'(load_done), 32'd0);
    check("after_busy_low", 32'(busy), 32'd0);
    check("after_ready_low", 32'(load_ready), 32'd0);
  endtask

  initial begin
    clear = 1'b0; fetch_req = 1'b0; address = '0; load_start = 1'b0;
    load_valid = 1'b0; load_data = '0; load_last = 1'b0;
    reset_model();
    #12;
    check("rst_instr", 32'(instruction), 32'd0);
    check("rst_valid", 32'(instr_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ready", 32'(load_ready), 32'd0);
    @(negedge clk);
    clear = 1'b1;

    // boot image readout, back to back
    fetch(8'd0); fetch(8'd5); fetch(8'd11); fetch(8'd12);
    // out of range, then hold
    fetch(8'd40);
    idle_cycle();
    fetch(8'(DEPTH - 1)); fetch(8'(DEPTH)); fetch(8'd255);

    for (int i = 0; i < 16; i++) begin
      fetch(8'($urandom_range(0, 63)));
      if ($urandom_range(0, 2) == 0) idle_cycle();
    end

    // full image, terminated by the last address
    start_load(1'b0, 8'd0);
    load_words(DEPTH, 1'b0, 1'b0, 1, 1'b0);
    fetch(8'd7); fetch(8'd0); fetch(8'(DEPTH - 1));

    // short image with fetches attempted during the load
    start_load(1'b0, 8'd0);
    load_words(3, 1'b1, 1'b1, 2, 1'b1);
    fetch(8'd0); fetch(8'd1); fetch(8'd2); fetch(8'd3);

    // load_start together with a fetch
    start_load(1'b1, 8'd1);
    load_words(4, 1'b1, 1'b0, 0, 1'b1);
    fetch(8'd1); fetch(8'd4);

    start_load(1'b0, 8'd0);
    load_words(DEPTH, 1'b0, 1'b1, 0, 1'b1);
    for (int i = 0; i < 10; i++) fetch(8'($urandom_range(0, DEPTH + 8)));

    // reset in the middle of a load
    start_load(1'b0, 8'd0);
    for (int i = 0; i < 5; i++) begin
      load_valid = 1'b1;
      load_data  = 8'hA0 + 8'(i);
      tick();
    end
    load_valid = 1'b0;
    #2;
    clear = 1'b0;
    #1;
    reset_model();
    check("abort_instr", 32'(instruction), 32'd0);
    check("abort_valid", 32'(instr_valid), 32'd0);
    check("abort_fault", 32'(fault), 32'd0);
    check("abort_ready", 32'(load_ready), 32'd0);
    check("abort_done", 32'(load_done), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    @(negedge clk);
    clear = 1'b1;
    fetch(8'd0); fetch(8'd4); fetch(8'd5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
